// File: rtl/mem_arbiter.sv
//==============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the memory controller's single request channel between
//            the instruction cache (4-byte reads) and the load/store buffer
//            (1/2/4-byte reads and writes).
//            - One transaction is latched and held until MC_done.
//            - On completion the owner receives a one-cycle success pulse.
//            - Pipeline flush drains in-flight reads; committed stores
//              always complete.
// Options  : MEM_ARB_ICACHE_BYPASS_EN adds a one-entry last-fetch buffer.
//            A repeated IC fetch that hits the buffer is answered without
//            issuing a controller request.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              IC_S,
    input  logic [ADDR_W-1:0] IC_pos,
    output logic              IC_success,
    output logic [DATA_W-1:0] IC_value,
    input  logic              LSB_S,
    input  logic              LSB_type,
    input  logic [ADDR_W-1:0] LSB_pos,
    input  logic [2:0]        LSB_len,
    input  logic [DATA_W-1:0] LSB_result,
    output logic              LSB_success,
    output logic [DATA_W-1:0] LSB_value,
    output logic              MC_S,
    output logic              MC_type,
    output logic [ADDR_W-1:0] MC_pos,
    output logic [2:0]        MC_len,
    output logic [DATA_W-1:0] MC_data,
    input  logic              MC_done,
    input  logic [DATA_W-1:0] MC_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic       c_OWN_LSB = 1'b0;
    localparam logic       c_OWN_IC  = 1'b1;
    localparam logic [3:0] c_LIMIT   = 4'(STARVE_LIMIT);

    state_t            r_state;
    logic [3:0]        r_ic_wait;
    logic              r_owner;

    state_t            w_state_nxt;
    logic [3:0]        w_ic_wait_nxt;
    logic              w_owner_nxt;
    logic              w_mc_s_nxt;
    logic              w_mc_type_nxt;
    logic [ADDR_W-1:0] w_mc_pos_nxt;
    logic [2:0]        w_mc_len_nxt;
    logic [DATA_W-1:0] w_mc_data_nxt;
    logic              w_ic_success_nxt;
    logic [DATA_W-1:0] w_ic_value_nxt;
    logic              w_lsb_success_nxt;
    logic [DATA_W-1:0] w_lsb_value_nxt;
    logic              w_grant_lsb;
    logic              w_grant_ic;

`ifdef MEM_ARB_ICACHE_BYPASS_EN
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_tag;
    logic [DATA_W-1:0] r_buf_data;
    logic              w_buf_valid_nxt;
    logic [ADDR_W-1:0] w_buf_tag_nxt;
    logic [DATA_W-1:0] w_buf_data_nxt;
    logic              w_buf_hit;
    logic              w_wr_hits_buf;
    logic [ADDR_W-1:0] w_lsb_end;

    // Buffer hit on an exact fetch address, and store overlap by word.
    always_comb begin
        w_lsb_end     = LSB_pos + ADDR_W'(LSB_len) - ADDR_W'(1);
        w_buf_hit     = r_buf_valid && (IC_pos == r_buf_tag);
        w_wr_hits_buf = r_buf_valid && LSB_type &&
                        ((LSB_pos[ADDR_W-1:2]   == r_buf_tag[ADDR_W-1:2]) ||
                         (w_lsb_end[ADDR_W-1:2] == r_buf_tag[ADDR_W-1:2]));
    end
`endif

    // Arbitration: LSB wins unless IC is waiting and has been skipped enough.
    always_comb begin
        w_grant_lsb = LSB_S && (!IC_S || (r_ic_wait < c_LIMIT));
        w_grant_ic  = IC_S && !w_grant_lsb;
    end

    // Next-state and next-output logic; every register holds by default
    // and the success pulses default low.
    always_comb begin
        w_state_nxt       = r_state;
        w_ic_wait_nxt     = r_ic_wait;
        w_owner_nxt       = r_owner;
        w_mc_s_nxt        = MC_S;
        w_mc_type_nxt     = MC_type;
        w_mc_pos_nxt      = MC_pos;
        w_mc_len_nxt      = MC_len;
        w_mc_data_nxt     = MC_data;
        w_ic_success_nxt  = 1'b0;
        w_ic_value_nxt    = IC_value;
        w_lsb_success_nxt = 1'b0;
        w_lsb_value_nxt   = LSB_value;
`ifdef MEM_ARB_ICACHE_BYPASS_EN
        w_buf_valid_nxt   = r_buf_valid;
        w_buf_tag_nxt     = r_buf_tag;
        w_buf_data_nxt    = r_buf_data;
`endif

        case (r_state)
            S_IDLE: begin
                if (!clr && w_grant_lsb) begin
                    w_owner_nxt   = c_OWN_LSB;
                    w_mc_s_nxt    = 1'b1;
                    w_mc_type_nxt = LSB_type;
                    w_mc_pos_nxt  = LSB_pos;
                    w_mc_len_nxt  = LSB_len;
                    w_mc_data_nxt = LSB_result;
                    w_state_nxt   = S_BUSY;
                    if (IC_S && (r_ic_wait < c_LIMIT)) begin
                        w_ic_wait_nxt = r_ic_wait + 4'd1;
                    end
`ifdef MEM_ARB_ICACHE_BYPASS_EN
                    if (w_wr_hits_buf) begin
                        w_buf_valid_nxt = 1'b0;
                    end
`endif
                end else if (!clr && w_grant_ic) begin
                    w_owner_nxt   = c_OWN_IC;
                    w_ic_wait_nxt = 4'd0;
`ifdef MEM_ARB_ICACHE_BYPASS_EN
                    if (w_buf_hit) begin
                        w_ic_success_nxt = 1'b1;
                        w_ic_value_nxt   = r_buf_data;
                        w_state_nxt      = S_GAP;
                    end else begin
                        w_mc_s_nxt    = 1'b1;
                        w_mc_type_nxt = 1'b0;
                        w_mc_pos_nxt  = IC_pos;
                        w_mc_len_nxt  = 3'd4;
                        w_mc_data_nxt = '0;
                        w_state_nxt   = S_BUSY;
                    end
`else
                    w_mc_s_nxt    = 1'b1;
                    w_mc_type_nxt = 1'b0;
                    w_mc_pos_nxt  = IC_pos;
                    w_mc_len_nxt  = 3'd4;
                    w_mc_data_nxt = '0;
                    w_state_nxt   = S_BUSY;
`endif
                end
            end

            S_BUSY: begin
                if (MC_done) begin
                    w_mc_s_nxt  = 1'b0;
                    w_state_nxt = S_GAP;
                    // A flushed read completing this cycle is dropped.
                    if (!(clr && !MC_type)) begin
                        if (r_owner == c_OWN_IC) begin
                            w_ic_success_nxt = 1'b1;
                            w_ic_value_nxt   = MC_value;
`ifdef MEM_ARB_ICACHE_BYPASS_EN
                            w_buf_valid_nxt  = 1'b1;
                            w_buf_tag_nxt    = MC_pos;
                            w_buf_data_nxt   = MC_value;
`endif
                        end else begin
                            w_lsb_success_nxt = 1'b1;
                            if (!MC_type) begin
                                w_lsb_value_nxt = MC_value;
                            end
                        end
                    end
                end else if (clr && !MC_type) begin
                    // Reads are abandoned but the controller must still finish.
                    w_state_nxt = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (MC_done) begin
                    w_mc_s_nxt  = 1'b0;
                    w_state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                if (!clr) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset dominates, rdy=0 freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ic_wait   <= 4'd0;
            r_owner     <= c_OWN_LSB;
            MC_S        <= 1'b0;
            MC_type     <= 1'b0;
            MC_pos      <= '0;
            MC_len      <= 3'd0;
            MC_data     <= '0;
            IC_success  <= 1'b0;
            IC_value    <= '0;
            LSB_success <= 1'b0;
            LSB_value   <= '0;
`ifdef MEM_ARB_ICACHE_BYPASS_EN
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
`endif
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_ic_wait   <= w_ic_wait_nxt;
            r_owner     <= w_owner_nxt;
            MC_S        <= w_mc_s_nxt;
            MC_type     <= w_mc_type_nxt;
            MC_pos      <= w_mc_pos_nxt;
            MC_len      <= w_mc_len_nxt;
            MC_data     <= w_mc_data_nxt;
            IC_success  <= w_ic_success_nxt;
            IC_value    <= w_ic_value_nxt;
            LSB_success <= w_lsb_success_nxt;
            LSB_value   <= w_lsb_value_nxt;
`ifdef MEM_ARB_ICACHE_BYPASS_EN
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_tag   <= w_buf_tag_nxt;
            r_buf_data  <= w_buf_data_nxt;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (default build).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        IC_S;
    logic [31:0] IC_pos;
    logic        IC_success;
    logic [31:0] IC_value;
    logic        LSB_S;
    logic        LSB_type;
    logic [31:0] LSB_pos;
    logic [2:0]  LSB_len;
    logic [31:0] LSB_result;
    logic        LSB_success;
    logic [31:0] LSB_value;
    logic        MC_S;
    logic        MC_type;
    logic [31:0] MC_pos;
    logic [2:0]  MC_len;
    logic [31:0] MC_data;
    logic        MC_done;
    logic [31:0] MC_value;

    int n_cmp;
    int n_err;

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W      (32),
        .DATA_W      (32)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .clr        (clr),
        .IC_S       (IC_S),
        .IC_pos     (IC_pos),
        .IC_success (IC_success),
        .IC_value   (IC_value),
        .LSB_S      (LSB_S),
        .LSB_type   (LSB_type),
        .LSB_pos    (LSB_pos),
        .LSB_len    (LSB_len),
        .LSB_result (LSB_result),
        .LSB_success(LSB_success),
        .LSB_value  (LSB_value),
        .MC_S       (MC_S),
        .MC_type    (MC_type),
        .MC_pos     (MC_pos),
        .MC_len     (MC_len),
        .MC_data    (MC_data),
        .MC_done    (MC_done),
        .MC_value   (MC_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when the values differ.
    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; rdy = 1'b1; clr = 1'b0;
        IC_S = 1'b0; IC_pos = '0;
        LSB_S = 1'b0; LSB_type = 1'b0; LSB_pos = '0; LSB_len = 3'd0; LSB_result = '0;
        MC_done = 1'b0; MC_value = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Controller answer after `lat` cycles of MC_S counted from the grant.
    task automatic mc_complete(input int lat, input logic [31:0] val);
        for (int i = 0; i < lat - 1; i++) step();
        MC_done  = 1'b1;
        MC_value = val;
        step();
        MC_done  = 1'b0;
    endtask

    logic        exp_ic [6];
    logic [31:0] exp_pos;

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_ic = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // ---------------- reset state
        do_reset();
        check_value("rst_mc_s",  32'(MC_S), 32'd0);
        check_value("rst_mc_pos", MC_pos, 32'd0);
        check_value("rst_mc_len", 32'(MC_len), 32'd0);
        check_value("rst_ic_succ", 32'(IC_success), 32'd0);
        check_value("rst_lsb_succ", 32'(LSB_success), 32'd0);
        check_value("rst_lsb_val", LSB_value, 32'd0);
        check_value("rst_ic_val", IC_value, 32'd0);

        // ---------------- LSB read len 4 at 0x100, 6-cycle controller
        LSB_S = 1'b1; LSB_type = 1'b0; LSB_pos = 32'h100; LSB_len = 3'd4;
        step();
        check_value("rd_mc_s", 32'(MC_S), 32'd1);
        check_value("rd_mc_pos", MC_pos, 32'h100);
        check_value("rd_mc_len", 32'(MC_len), 32'd4);
        check_value("rd_mc_type", 32'(MC_type), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_value("rd_mc_s_hold", 32'(MC_S), 32'd1);
            check_value("rd_no_early_succ", 32'(LSB_success), 32'd0);
        end
        MC_done = 1'b1; MC_value = 32'hDEADBEEF;
        step();
        MC_done = 1'b0; LSB_S = 1'b0;
        check_value("rd_mc_s_drop", 32'(MC_S), 32'd0);
        check_value("rd_lsb_succ", 32'(LSB_success), 32'd1);
        check_value("rd_lsb_val", LSB_value, 32'hDEADBEEF);
        check_value("rd_ic_succ", 32'(IC_success), 32'd0);
        step();
        check_value("rd_succ_once", 32'(LSB_success), 32'd0);
        check_value("rd_gap_idle", 32'(MC_S), 32'd0);

        // ---------------- starvation: both requests held continuously
        do_reset();
        IC_S = 1'b1; IC_pos = 32'h40;
        LSB_S = 1'b1; LSB_type = 1'b0; LSB_pos = 32'h300; LSB_len = 3'd4;
        step();
        for (int g = 0; g < 6; g++) begin
            exp_pos = exp_ic[g] ? 32'h40 : 32'h300;
            check_value($sformatf("starve_mc_s_%0d", g), 32'(MC_S), 32'd1);
            check_value($sformatf("starve_pos_%0d", g), MC_pos, exp_pos);
            mc_complete(1, 32'h1000 + g);
            check_value($sformatf("starve_ic_succ_%0d", g), 32'(IC_success), 32'(exp_ic[g]));
            check_value($sformatf("starve_lsb_succ_%0d", g), 32'(LSB_success), 32'(!exp_ic[g]));
            check_value($sformatf("starve_mc_off_%0d", g), 32'(MC_S), 32'd0);
            step();
            check_value($sformatf("starve_gap_%0d", g), 32'(MC_S), 32'd0);
            step();
        end
        check_value("starve_ic_val", IC_value, 32'h1004);
        check_value("starve_lsb_val", LSB_value, 32'h1005);

        // ---------------- LSB write len 2 at 0x200 with flush mid-BUSY
        do_reset();
        LSB_S = 1'b1; LSB_type = 1'b1; LSB_pos = 32'h200; LSB_len = 3'd2;
        LSB_result = 32'h0000BEEF;
        step();
        check_value("wr_mc_type", 32'(MC_type), 32'd1);
        check_value("wr_mc_data", MC_data, 32'h0000BEEF);
        check_value("wr_mc_len", 32'(MC_len), 32'd2);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_value("wr_clr_hold", 32'(MC_S), 32'd1);
        step();
        check_value("wr_clr_hold2", 32'(MC_S), 32'd1);
        MC_done = 1'b1; MC_value = 32'h12345678;
        step();
        MC_done = 1'b0; LSB_S = 1'b0;
        check_value("wr_lsb_succ", 32'(LSB_success), 32'd1);
        check_value("wr_lsb_val_kept", LSB_value, 32'd0);
        check_value("wr_mc_s_drop", 32'(MC_S), 32'd0);
        step();

        // ---------------- IC read at 0x40 flushed into DRAIN
        do_reset();
        IC_S = 1'b1; IC_pos = 32'h40;
        step();
        check_value("dr_mc_s", 32'(MC_S), 32'd1);
        check_value("dr_mc_len", 32'(MC_len), 32'd4);
        step();
        step();
        clr = 1'b1; IC_S = 1'b0;
        step();
        check_value("dr_mc_s_hold", 32'(MC_S), 32'd1);
        step();
        clr = 1'b0;
        check_value("dr_mc_s_hold2", 32'(MC_S), 32'd1);
        MC_done = 1'b1; MC_value = 32'h00001234;
        step();
        MC_done = 1'b0;
        check_value("dr_mc_s_drop", 32'(MC_S), 32'd0);
        check_value("dr_no_ic_succ", 32'(IC_success), 32'd0);
        check_value("dr_ic_val_kept", IC_value, 32'd0);
        IC_S = 1'b1; IC_pos = 32'h80;
        step();
        check_value("dr_gap_no_grant", 32'(MC_S), 32'd0);
        check_value("dr_gap_no_succ", 32'(IC_success), 32'd0);
        step();
        check_value("dr_regrant", 32'(MC_S), 32'd1);
        check_value("dr_regrant_pos", MC_pos, 32'h80);
        mc_complete(2, 32'hCAFEF00D);
        IC_S = 1'b0;
        check_value("dr_ic_succ", 32'(IC_success), 32'd1);
        check_value("dr_ic_val", IC_value, 32'hCAFEF00D);
        step();

        // ---------------- rdy freeze mid-BUSY with MC_done during the freeze
        do_reset();
        LSB_S = 1'b1; LSB_type = 1'b0; LSB_pos = 32'h400; LSB_len = 3'd1;
        step();
        step();
        rdy = 1'b0; MC_done = 1'b1; MC_value = 32'h00000055;
        step();
        MC_done = 1'b0;
        check_value("frz_mc_s", 32'(MC_S), 32'd1);
        check_value("frz_no_succ", 32'(LSB_success), 32'd0);
        step();
        step();
        check_value("frz_mc_s2", 32'(MC_S), 32'd1);
        rdy = 1'b1;
        step();
        check_value("frz_resume_busy", 32'(MC_S), 32'd1);
        check_value("frz_resume_no_succ", 32'(LSB_success), 32'd0);
        MC_done = 1'b1; MC_value = 32'h000000AA;
        step();
        MC_done = 1'b0; LSB_S = 1'b0;
        check_value("frz_succ", 32'(LSB_success), 32'd1);
        check_value("frz_val", LSB_value, 32'h000000AA);
        step();

        // ---------------- reset during BUSY
        do_reset();
        LSB_S = 1'b1; LSB_type = 1'b0; LSB_pos = 32'h500; LSB_len = 3'd4;
        step();
        check_value("mr_mc_s", 32'(MC_S), 32'd1);
        step();
        rst = 1'b0; MC_done = 1'b1; MC_value = 32'h77777777;
        step();
        check_value("mr_mc_s_off", 32'(MC_S), 32'd0);
        check_value("mr_mc_pos_off", MC_pos, 32'd0);
        check_value("mr_mc_len_off", 32'(MC_len), 32'd0);
        check_value("mr_no_succ", 32'(LSB_success), 32'd0);
        check_value("mr_lsb_val", LSB_value, 32'd0);
        rst = 1'b1; MC_done = 1'b0; LSB_S = 1'b0;
        step();
        check_value("mr_idle_mc_s", 32'(MC_S), 32'd0);
        check_value("mr_idle_no_succ", 32'(LSB_success), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
